pipemem_mmio: RTL

Parametrised MEM-stage block for the pipelined CPU: synchronous word-addressed data RAM plus a memory-mapped IO window, selected by one address bit.
- Byte, halfword and word loads/stores with sign or zero extension.
- Configurable number of output and input ports; input ports are double-synchronised.
- Input-change detection with a read-to-clear status register; alignment-error flag.

---
 rtl/pipemem_mmio.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pipemem_mmio.sv
// pipemem_mmio: MEM stage with a word-addressed data RAM and an MMIO window.
// Define MMIO_IRQ_EN to add the MASK register (index 17) and the irq output.
module pipemem_mmio #(
    parameter int DEPTH_LOG2 = 5,
    parameter int NUM_OUT    = 3,
    parameter int NUM_IN     = 2,
    parameter int IO_BIT     = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [31:0]           addr,
    input  logic [31:0]           datain,
    output logic [31:0]           dataout,
    output logic                  err,
    output logic [32*NUM_OUT-1:0] out_ports,
`ifdef MMIO_IRQ_EN
    output logic                  irq,
`endif
    input  logic [32*NUM_IN-1:0]  in_ports
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]              r_mem [DEPTH];
    logic [NUM_OUT-1:0][31:0] r_out;
    logic [NUM_IN-1:0][31:0]  r_sync1;
    logic [NUM_IN-1:0][31:0]  r_sync2;
    logic [NUM_IN-1:0][31:0]  r_prev;
    logic [NUM_IN-1:0]        r_changed;
    logic                     r_err;
    logic [31:0]              r_dout;
`ifdef MMIO_IRQ_EN
    logic [NUM_IN-1:0]        r_mask;
    logic                     r_irq;
`endif

    logic                  w_io;
    logic [4:0]            w_idx;
    logic [DEPTH_LOG2-1:0] w_widx;
    logic                  w_misalign;
    logic                  w_both;
    logic                  w_mis_acc;
    logic                  w_bad;
    logic                  w_st;
    logic                  w_ld;
    logic                  w_stat_rd;
    logic [NUM_IN-1:0]     w_set;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rword;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_ram_rd;
    logic [31:0]           w_io_rd;
    logic [31:0]           w_status;
    logic                  w_unused;

    assign w_io     = addr[IO_BIT];
    assign w_idx    = addr[6:2];
    assign w_widx   = addr[DEPTH_LOG2+1:2];
    assign w_unused = ^addr;

    // The IO window only accepts whole-word accesses.
    always_comb begin
        w_misalign = 1'b0;
        unique case (size)
            2'b00:   w_misalign = w_io;
            2'b01:   w_misalign = w_io | addr[0];
            2'b10:   w_misalign = addr[1] | addr[0];
            default: w_misalign = 1'b1;
        endcase
    end

    assign w_both    = we & re;
    assign w_mis_acc = (we ^ re) & w_misalign;
    assign w_bad     = w_both | w_mis_acc;
    assign w_st      = we & ~re & ~w_misalign;
    assign w_ld      = re & ~we & ~w_misalign;
    assign w_stat_rd = w_ld & w_io & (w_idx == 5'd16);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = datain;
        unique case (size)
            2'b00: begin
                w_be    = 4'b0001 << addr[1:0];
                w_wdata = {4{datain[7:0]}};
            end
            2'b01: begin
                w_be    = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{datain[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_st && !w_io) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
    end

    assign w_rword = r_mem[w_widx];
    assign w_byte  = w_rword[{addr[1:0], 3'b000} +: 8];
    assign w_half  = addr[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_ram_rd = w_rword;
        unique case (size)
            2'b00:   w_ram_rd = {{24{sign_ext & w_byte[7]}}, w_byte};
            2'b01:   w_ram_rd = {{16{sign_ext & w_half[15]}}, w_half};
            default: ;
        endcase
    end

    assign w_status = {r_err, {(31-NUM_IN){1'b0}}, r_changed};

    always_comb begin
        w_io_rd = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (w_idx == 5'(i)) w_io_rd = r_out[i];
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_idx == 5'(8 + i)) w_io_rd = r_sync2[i];
        end
        if (w_idx == 5'd16) w_io_rd = w_status;
`ifdef MMIO_IRQ_EN
        if (w_idx == 5'd17) w_io_rd = 32'(r_mask);
`endif
    end

    always_comb begin
        w_set = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_set[i] = (r_sync2[i] != r_prev[i]);
        end
    end

    // Set events on the STATUS read edge take priority over its clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dout    <= '0;
            r_out     <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_changed <= '0;
            r_err     <= 1'b0;
        end else begin
            r_sync1   <= in_ports;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_changed <= (w_stat_rd ? '0 : r_changed) | w_set;
            r_err     <= (r_err & ~w_stat_rd) | w_bad;
            if (w_mis_acc) begin
                r_dout <= '0;
            end else if (w_ld) begin
                r_dout <= w_io ? w_io_rd : w_ram_rd;
            end
            if (w_st && w_io) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (w_idx == 5'(i)) r_out[i] <= datain;
                end
            end
        end
    end

`ifdef MMIO_IRQ_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_st && w_io && (w_idx == 5'd17)) r_mask <= datain[NUM_IN-1:0];
            r_irq <= |(r_changed & r_mask);
        end
    end

    assign irq = r_irq;
`endif

    assign dataout   = r_dout;
    assign err       = r_err;
    assign out_ports = r_out;

endmodule
